// File: rtl/mp_add_seq_pkg.sv
// Shared widths and FSM state type for the multi-precision add/subtract sequencer.
package mp_add_seq_pkg;

    localparam int DW_DEF   = 8;
    localparam int MAXB_DEF = 16;
    localparam int IDXW     = $clog2(MAXB_DEF);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/mp_add_fsm.sv
// Packet framing for the sequencer: resolves first/last/index of each accepted byte,
// latches the packet's subtract mode and flags protocol errors.
//   state  | meaning
//   IDLE   | no packet open; next accepted byte starts one
//   ACTIVE | packet open; bytes extend it until last
module mp_add_fsm
    import mp_add_seq_pkg::*;
#(
    parameter int MAXB = MAXB_DEF,
    parameter int IW   = $clog2(MAXB)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          accept_i,
    input  logic          first_i,
    input  logic          last_i,
    input  logic          sub_i,
    output logic          byte_first_o,
    output logic          byte_last_o,
    output logic [IW-1:0] byte_idx_o,
    output logic          sub_o,
    output logic          err_o
);

    fsm_state_e    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          sub_q, sub_d;
    logic          err_q, err_d;
    logic          at_limit;

    always_comb begin
        byte_first_o = (state_q == IDLE) || first_i;
        byte_idx_o   = byte_first_o ? '0 : idx_q;
        at_limit     = (byte_idx_o == IW'(MAXB - 1));
        byte_last_o  = last_i || at_limit;
        state_d      = state_q;
        idx_d        = idx_q;
        sub_d        = sub_q;
        err_d        = err_q;
        if (accept_i) begin
            idx_d   = byte_idx_o + 1'b1;
            state_d = byte_last_o ? IDLE : ACTIVE;
            if (byte_first_o) begin
                sub_d = sub_i;
            end
            // A restart inside a packet or an overlong packet is both recovered and remembered.
            if ((state_q == ACTIVE && first_i) || (at_limit && !last_i)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sub_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            err_q   <= err_d;
        end
    end

    assign sub_o = sub_q;
    assign err_o = err_q;

endmodule

// File: rtl/mp_add_seq.sv
// Byte-serial multi-precision add/subtract around an external DW-bit adder:
// S1 holds operands feeding the adder, S2 registers the sum byte and end-of-packet flags.
module mp_add_seq
    import mp_add_seq_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int MAXB = MAXB_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    VDD,
    input  logic                    VSS,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_a,
    input  logic [DW-1:0]           in_b,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic                    in_sub,
    output logic [DW-1:0]           add_a,
    output logic [DW-1:0]           add_b,
    output logic                    add_cin,
    input  logic [DW-1:0]           add_y,
    input  logic                    add_cout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DW-1:0]           out_sum,
    output logic [$clog2(MAXB)-1:0] out_idx,
    output logic                    out_last,
    output logic                    out_cout,
    output logic                    out_ovf,
    output logic                    err_seq
);

    localparam int IW = $clog2(MAXB);

    logic          accept, s2_load, ovf_raw;
    logic          byte_first, byte_last, sub_q;
    logic [IW-1:0] byte_idx;

    logic          s1_valid_q, s1_first_q, s1_last_q;
    logic [DW-1:0] s1_a_q, s1_b_q;
    logic [IW-1:0] s1_idx_q;

    logic          out_valid_q, out_last_q, out_cout_q, out_ovf_q, carry_q;
    logic [DW-1:0] out_sum_q;
    logic [IW-1:0] out_idx_q;

    logic          unused_supply;
    assign unused_supply = VDD ^ VSS;

    mp_add_fsm #(.MAXB(MAXB), .IW(IW)) u_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .accept_i     (accept),
        .first_i      (in_first),
        .last_i       (in_last),
        .sub_i        (in_sub),
        .byte_first_o (byte_first),
        .byte_last_o  (byte_last),
        .byte_idx_o   (byte_idx),
        .sub_o        (sub_q),
        .err_o        (err_seq)
    );

    assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign accept   = in_valid && in_ready;

    // sub_q already belongs to the byte in S1: it only changes on an accept, when S1 is refilled.
    assign add_a   = s1_a_q;
    assign add_b   = sub_q ? ~s1_b_q : s1_b_q;
    assign add_cin = s1_first_q ? sub_q : carry_q;
    assign ovf_raw = add_cout ^ (add_a[DW-1] ^ add_b[DW-1] ^ add_y[DW-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_idx_q   <= '0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_first_q <= byte_first;
            s1_last_q  <= byte_last;
            s1_a_q     <= in_a;
            s1_b_q     <= in_b;
            s1_idx_q   <= byte_idx;
        end else if (s2_load) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            carry_q     <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= add_y;
            out_idx_q   <= s1_idx_q;
            out_last_q  <= s1_last_q;
            out_cout_q  <= s1_last_q & add_cout;
            out_ovf_q   <= s1_last_q & ovf_raw;
            carry_q     <= add_cout;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_cout  = out_cout_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq: behavioural adder, whole-integer reference model.
module tb_mp_add_seq;

    typedef struct packed {
        logic [7:0] sum;
        logic [3:0] idx;
        logic       last;
        logic       cout;
        logic       ovf;
    } beat_t;

    logic       clk, rst_n, VDD, VSS;
    logic       in_valid, in_ready, in_first, in_last, in_sub;
    logic [7:0] in_a, in_b, add_a, add_b, add_y, out_sum;
    logic       add_cin, add_cout;
    logic       out_valid, out_ready, out_last, out_cout, out_ovf, err_seq;
    logic [3:0] out_idx;

    int    checks = 0;
    int    errors = 0;
    beat_t obs_q[$];
    beat_t exp_q[$];

    mp_add_seq dut (
        .clk(clk), .rst_n(rst_n), .VDD(VDD), .VSS(VSS),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_first(in_first), .in_last(in_last), .in_sub(in_sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_y(add_y), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_idx(out_idx),
        .out_last(out_last), .out_cout(out_cout), .out_ovf(out_ovf), .err_seq(err_seq)
    );

    assign {add_cout, add_y} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n && out_valid && out_ready)
            obs_q.push_back(beat_t'{out_sum, out_idx, out_last, out_cout, out_ovf});

    initial begin
        #800000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    // Packet of n bytes computed as one big integer: A + B or A - B (as A + ~B + 1).
    function automatic void ref_packet(input logic [127:0] a, input logic [127:0] b,
                                       input int n, input logic sub);
        logic [128:0] ma, mb, r;
        logic         sa, sb, sr;
        beat_t        e;
        ma = '0;
        mb = '0;
        for (int i = 0; i < n; i++) begin
            ma[8*i +: 8] = a[8*i +: 8];
            mb[8*i +: 8] = sub ? ~b[8*i +: 8] : b[8*i +: 8];
        end
        r  = ma + mb + {128'd0, sub};
        sa = a[8*n-1];
        sb = b[8*n-1];
        sr = r[8*n-1];
        for (int i = 0; i < n; i++) begin
            e.sum  = r[8*i +: 8];
            e.idx  = 4'(i);
            e.last = (i == n - 1);
            e.cout = e.last ? r[8*n] : 1'b0;
            e.ovf  = e.last ? (sub ? (sa != sb && sr != sa) : (sa == sb && sr != sa)) : 1'b0;
            exp_q.push_back(e);
        end
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] a, input logic [7:0] b,
                              input logic first, input logic last, input logic sub);
        bit got = 0;
        in_a = a; in_b = b; in_first = first; in_last = last; in_sub = sub;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (got) @(posedge clk);
        else begin
            errors++;
            $display("FAIL drive_timeout in_ready got 0 want 1");
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n);
        for (int k = 0; k < 400 && obs_q.size() < n; k++) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if (err_seq !== 1'b0) begin errors++; $display("FAIL reset_err_seq got %b want 0", err_seq); end
        checks++;
        if (add_cin !== 1'b0) begin errors++; $display("FAIL reset_add_cin got %b want 0", add_cin); end
    endtask

    task automatic test_add_basic();
        apply_reset();
        drive_byte(8'hFF, 8'h01, 1, 0, 0);
        checks++;
        if ({add_a, add_b, add_cin} !== {8'hFF, 8'h01, 1'b0})
            begin errors++; $display("FAIL add_s1_byte0 got %h %h %b want ff 01 0", add_a, add_b, add_cin); end
        drive_byte(8'h12, 8'h00, 0, 1, 0);
        checks++;
        if ({add_a, add_cin} !== {8'h12, 1'b1})
            begin errors++; $display("FAIL add_s1_byte1 got %h %b want 12 1", add_a, add_cin); end
        exp_q.push_back(beat_t'{8'h00, 4'd0, 1'b0, 1'b0, 1'b0});
        exp_q.push_back(beat_t'{8'h13, 4'd1, 1'b1, 1'b0, 1'b0});
        wait_obs(2);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
                begin errors++; $display("FAIL add_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_sub();
        apply_reset();
        drive_byte(8'h00, 8'h01, 1, 0, 1);
        checks++;
        if ({add_b, add_cin} !== {8'hFE, 1'b1})
            begin errors++; $display("FAIL sub_s1_byte0 got %h %b want fe 1", add_b, add_cin); end
        drive_byte(8'h01, 8'h00, 0, 1, 0);
        exp_q.push_back(beat_t'{8'hFF, 4'd0, 1'b0, 1'b0, 1'b0});
        exp_q.push_back(beat_t'{8'h00, 4'd1, 1'b1, 1'b1, 1'b0});
        wait_obs(2);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
                begin errors++; $display("FAIL sub_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_ovf();
        apply_reset();
        drive_byte(8'h7F, 8'h01, 1, 1, 0);
        drive_byte(8'h80, 8'h01, 1, 1, 1);
        exp_q.push_back(beat_t'{8'h80, 4'd0, 1'b1, 1'b0, 1'b1});
        exp_q.push_back(beat_t'{8'h7F, 4'd0, 1'b1, 1'b1, 1'b1});
        wait_obs(2);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
                begin errors++; $display("FAIL ovf_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] a, b;
        logic         sub;
        apply_reset();
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        sub = 1'($urandom_range(0, 1));
        ref_packet(a, b, 4, sub);
        fork
            for (int i = 0; i < 4; i++)
                drive_byte(a[8*i +: 8], b[8*i +: 8], i == 0, i == 3, sub);
            begin
                logic [7:0] held;
                int         k;
                for (k = 0; k < 50; k++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) break;
                end
                checks++;
                if (k >= 50) begin errors++; $display("FAIL bp_first_valid got 0 want 1"); end
                out_ready = 1'b0;
                held = out_sum;
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (out_valid !== 1'b1 || out_sum !== held)
                        begin errors++; $display("FAIL bp_hold got %b %h want 1 %h", out_valid, out_sum, held); end
                end
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
                out_ready = 1'b1;
            end
        join
        wait_obs(4);
        checks++;
        if (obs_q.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", obs_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
                begin errors++; $display("FAIL bp_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bit done = 0;
        apply_reset();
        fork
            begin
                for (int p = 0; p < 25; p++) begin
                    logic [127:0] a, b;
                    logic         sub;
                    int           n;
                    n   = (p == 0) ? 16 : int'($urandom_range(1, 16));
                    a   = {$urandom, $urandom, $urandom, $urandom};
                    b   = {$urandom, $urandom, $urandom, $urandom};
                    sub = 1'($urandom_range(0, 1));
                    ref_packet(a, b, n, sub);
                    for (int i = 0; i < n; i++)
                        drive_byte(a[8*i +: 8], b[8*i +: 8], i == 0, i == n - 1,
                                   (i == 0) ? sub : 1'($urandom_range(0, 1)));
                end
                done = 1;
            end
            while (!done) begin
                @(posedge clk);
                #1 out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready = 1'b1;
        wait_obs(exp_q.size());
        checks++;
        if (obs_q.size() != exp_q.size())
            begin errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
                begin errors++; $display("FAIL rand_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++;
        if (err_seq !== 1'b0) begin errors++; $display("FAIL rand_err_seq got %b want 0", err_seq); end
    endtask

    task automatic test_err_first();
        apply_reset();
        drive_byte(8'h01, 8'h01, 1, 0, 0);
        drive_byte(8'h01, 8'h01, 0, 0, 1);
        checks++;
        if (err_seq !== 1'b0) begin errors++; $display("FAIL errf_before got %b want 0", err_seq); end
        drive_byte(8'h05, 8'h03, 1, 0, 1);
        drive_byte(8'h00, 8'h00, 0, 1, 0);
        checks++;
        if (err_seq !== 1'b1) begin errors++; $display("FAIL errf_after got %b want 1", err_seq); end
        exp_q.push_back(beat_t'{8'h02, 4'd0, 1'b0, 1'b0, 1'b0});
        exp_q.push_back(beat_t'{8'h02, 4'd1, 1'b0, 1'b0, 1'b0});
        exp_q.push_back(beat_t'{8'h02, 4'd0, 1'b0, 1'b0, 1'b0});
        exp_q.push_back(beat_t'{8'h00, 4'd1, 1'b1, 1'b1, 1'b0});
        wait_obs(4);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
                begin errors++; $display("FAIL errf_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_maxb();
        logic [7:0] a;
        apply_reset();
        checks++;
        if (err_seq !== 1'b0) begin errors++; $display("FAIL maxb_cleared got %b want 0", err_seq); end
        for (int i = 0; i < 17; i++) begin
            a = 8'($urandom);
            drive_byte(a, 8'h00, i == 0, i == 16, 0);
            exp_q.push_back(beat_t'{a, (i == 16) ? 4'd0 : 4'(i), (i >= 15), 1'b0, 1'b0});
        end
        wait_obs(17);
        checks++;
        if (err_seq !== 1'b1) begin errors++; $display("FAIL maxb_err got %b want 1", err_seq); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
                begin errors++; $display("FAIL maxb_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive_byte(8'h11, 8'h22, 1, 0, 1);
        drive_byte(8'h33, 8'h44, 0, 0, 0);
        checks++;
        if ({out_valid, in_ready} !== 2'b10)
            begin errors++; $display("FAIL arst_full got %b%b want 10", out_valid, in_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, err_seq} !== 3'b010)
            begin errors++; $display("FAIL arst_now got %b%b%b want 010", out_valid, in_ready, err_seq); end
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        obs_q.delete();
        exp_q.delete();
        drive_byte(8'hAA, 8'h55, 0, 1, 0);
        checks++;
        if ({add_b, add_cin} !== {8'h55, 1'b0})
            begin errors++; $display("FAIL arst_s1 got %h %b want 55 0", add_b, add_cin); end
        exp_q.push_back(beat_t'{8'hFF, 4'd0, 1'b1, 1'b0, 1'b0});
        wait_obs(1);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i])
                begin errors++; $display("FAIL arst_beat%0d got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        VDD = 1'b1;
        VSS = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0; in_b = '0;
        in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_add_basic();
        test_sub();
        test_ovf();
        test_backpressure();
        test_random();
        test_err_first();
        test_maxb();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
